// File: rtl/safe_pkg.sv
// Shared definitions for the safe keypad encoder: key codes, FSM states,
// the "no key" candidate encoding and small snapshot helpers.
package safe_pkg;

    localparam logic [3:0] KEY_0       = 4'h0;
    localparam logic [3:0] KEY_1       = 4'h1;
    localparam logic [3:0] KEY_2       = 4'h2;
    localparam logic [3:0] KEY_3       = 4'h3;
    localparam logic [3:0] KEY_4       = 4'h4;
    localparam logic [3:0] KEY_5       = 4'h5;
    localparam logic [3:0] KEY_6       = 4'h6;
    localparam logic [3:0] KEY_7       = 4'h7;
    localparam logic [3:0] KEY_8       = 4'h8;
    localparam logic [3:0] KEY_9       = 4'h9;
    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [3:0] KEY_LOCK    = 4'hC;
    localparam logic [3:0] KEY_SPARE_D = 4'hD;
    localparam logic [3:0] KEY_SPARE_E = 4'hE;
    localparam logic [3:0] KEY_SPARE_F = 4'hF;

    // A candidate is a 4-bit key index; MSB set means "no single key down".
    localparam logic [4:0] CAND_NONE = 5'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } kp_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, v[i]};
        end
        return cnt;
    endfunction

    // Index of the only set bit, or CAND_NONE for zero or several bits.
    function automatic logic [4:0] snap_to_cand(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = i[3:0];
        end
        return (popcount16(v) == 5'd1) ? {1'b0, idx} : CAND_NONE;
    endfunction

endpackage

// File: rtl/safe_sync_2ff.sv
// Two-flop synchronizer of configurable width with a configurable reset value.
module safe_sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/safe_keypad_encoder.sv
// 4x4 keypad scanner, debouncer and key-code initiator for the safe.
// Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat of a held key.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a single key stable for DEBOUNCE_SCANS scans
// SEND    | key_valid high, key_code held until key_ready
// RELEASE | waiting for DEBOUNCE_SCANS empty scans (or a repeat)
module safe_keypad_encoder #(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       multi_key
);
    import safe_pkg::*;

    localparam int                 DIV_W   = $clog2(SCAN_DIV);
    localparam int                 STB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0]   DIV_TC  = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0]   STB_MAX = STB_W'(DEBOUNCE_SCANS);

    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      snap_q, snap_d;
    logic [4:0]       cand_q, cand_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic             multi_q, multi_d;
    kp_state_e        state_q, state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic             scan_tc, eos, scan_multi, rep_hit;
    logic [15:0]      full_snap;
    logic [4:0]       scan_cand;

    // Rows idle high, so the synchronizer resets to all ones.
    safe_sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_s)
    );

    // Column divider, snapshot capture and end-of-scan debounce evaluation.
    always_comb begin
        scan_tc   = ena && (div_q == DIV_TC);
        eos       = scan_tc && (col_q == 2'd3);
        full_snap = snap_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) full_snap[{r[1:0], col_q}] = 1'b1;
        end
        scan_cand  = snap_to_cand(full_snap);
        scan_multi = (popcount16(full_snap) > 5'd1);

        div_d    = div_q;
        col_d    = col_q;
        snap_d   = snap_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        multi_d  = multi_q;
        if (ena) begin
            if (scan_tc) begin
                div_d = '0;
                col_d = col_q + 2'd1;
                if (eos) begin
                    snap_d   = '0;
                    cand_d   = scan_cand;
                    multi_d  = scan_multi;
                    if (scan_cand == cand_q)
                        stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + 1'b1;
                    else
                        stable_d = STB_W'(1);
                end else begin
                    snap_d = full_snap;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Count full scans where the delivered key is still the only key down.
    always_comb begin
        rep_d   = rep_q;
        rep_hit = 1'b0;
        if (state_q != RELEASE) begin
            rep_d = '0;
        end else if (eos) begin
            if (scan_cand == {1'b0, key_code_q}) begin
                if (rep_q == REP_LAST) begin
                    rep_hit = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end else begin
                rep_d = '0;
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    // Repeat disabled; the parameter is kept only so both builds share one interface.
    assign rep_hit = (REPEAT_SCANS < 0);
`endif

    // Delivery FSM: next state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        case (state_q)
            IDLE: begin
                if (eos && (stable_d == STB_MAX) && (scan_cand != CAND_NONE)) begin
                    key_code_d  = scan_cand[3:0];
                    key_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (key_valid_q && key_ready) begin
                    key_valid_d = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                if (eos && (stable_d == STB_MAX) && (scan_cand == CAND_NONE)) begin
                    state_d = IDLE;
                end else if (rep_hit) begin
                    key_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            default: begin
                key_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            col_q       <= '0;
            snap_q      <= '0;
            cand_q      <= CAND_NONE;
            stable_q    <= '0;
            multi_q     <= 1'b0;
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            multi_q     <= multi_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_n     = ena ? ~(4'b0001 << col_q) : 4'hF;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_safe_keypad_encoder.sv
// Scoreboard bench for safe_keypad_encoder with a behavioural 4x4 key matrix.
module tb_safe_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int REP      = 8;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
    localparam int LAT_MAX  = 3 * SCAN_CYC + 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        ena       = 1'b1;
    logic        key_ready = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        multi_key;
    logic [15:0] pressed   = '0;

    int          checks      = 0;
    int          errors      = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;
    bit          allow_repeat = 1'b0;
    int          repeat_seen  = 0;
    int          bad;

    safe_keypad_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Monitor: every handshake transfer is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL delivery: key_code=%h expected %h", key_code, mon_exp);
                end
            end else if (allow_repeat && key_code == 4'h3) begin
                repeat_seen++;
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: key_code=%h expected none", key_code);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!key_valid && n < max_cyc) begin
            cyc(1);
            n++;
        end
        checks++;
        if (!key_valid) begin
            errors++;
            $display("FAIL %s: key_valid=0 after %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    initial begin
        // Reset state.
        #12;
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_multi", multi_key, 1'b0);
        chk("rst_code", key_code, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(5 * SCAN_CYC);

        // Single press of key 9 (row 2, col 1) with ready high.
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid("t2_latency", LAT_MAX);
        cyc(1);
        chk("t2_pulse_end", key_valid, 1'b0);
        cyc(6 * SCAN_CYC);
        pressed = '0;
        cyc(5 * SCAN_CYC);
        chk("t2_drain", exp_q.size(), 0);

        // Backpressure; key released while waiting.
        key_ready = 1'b0;
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid("t3_valid", LAT_MAX);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) pressed = '0;
            if (!key_valid || key_code != 4'h9) bad++;
            cyc(1);
        end
        chk("t3_hold_stable", bad, 0);
        chk("t3_code", key_code, 4'h9);
        key_ready = 1'b1;
        cyc(1);
        chk("t3_valid_drop", key_valid, 1'b0);
        cyc(5 * SCAN_CYC);
        chk("t3_drain", exp_q.size(), 0);

        // Bounce on alternate scans, then a stable press.
        for (int i = 0; i < 10; i++) begin
            pressed[9] = (i % 2 == 0);
            cyc(SCAN_CYC);
        end
        chk("t4_no_bounce_valid", key_valid, 1'b0);
        exp_q.push_back(4'h9);
        pressed[9] = 1'b1;
        wait_valid("t4_after_bounce", LAT_MAX);
        cyc(2);
        pressed = '0;
        cyc(5 * SCAN_CYC);
        chk("t4_drain", exp_q.size(), 0);

        // Two keys down, then release one.
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        cyc(2 * SCAN_CYC);
        for (int i = 0; i < 3; i++) begin
            chk("t5_multi", multi_key, 1'b1);
            chk("t5_no_valid", key_valid, 1'b0);
            cyc(SCAN_CYC);
        end
        exp_q.push_back(4'h0);
        pressed[5] = 1'b0;
        wait_valid("t5_key0", LAT_MAX);
        cyc(2);
        chk("t5_multi_clear", multi_key, 1'b0);
        pressed = '0;
        cyc(5 * SCAN_CYC);
        chk("t5_drain", exp_q.size(), 0);

        // Scan frozen by ena, then held key 3 past the repeat interval.
        ena = 1'b0;
        cyc(3);
        chk("t6_col_off", col_n, 4'hF);
        pressed[3] = 1'b1;
        cyc(10 * SCAN_CYC);
        chk("t6_col_off_hold", col_n, 4'hF);
        chk("t6_no_valid", key_valid, 1'b0);
        ena = 1'b1;
`ifdef KEYPAD_REPEAT_EN
        allow_repeat = 1'b1;
`endif
        exp_q.push_back(4'h3);
        wait_valid("t6_key3", LAT_MAX);
        cyc((REP + 6) * SCAN_CYC);
        pressed = '0;
        cyc(5 * SCAN_CYC);
        allow_repeat = 1'b0;
        chk("t6_drain", exp_q.size(), 0);
`ifdef KEYPAD_REPEAT_EN
        chk("t6_repeat_seen", (repeat_seen > 0), 1'b1);
`endif

        // Reset with a key pending: it must be dropped.
        key_ready = 1'b0;
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid("t1_pending", LAT_MAX);
        cyc(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_col_n", col_n, 4'b1110);
        chk("t1_rst_valid", key_valid, 1'b0);
        chk("t1_rst_multi", multi_key, 1'b0);
        chk("t1_rst_code", key_code, 4'h0);
        exp_q.delete();
        pressed = '0;
        key_ready = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(5 * SCAN_CYC);
        chk("t1_nothing_delivered", key_valid, 1'b0);
        chk("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
